// File: rtl/systolic_drain.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_drain
//  Brief    : Walks the systolic array diagonal read port, requantizes each
//             accumulator vector (rounding shift, saturation, optional ReLU)
//             and writes one packed word per index to the output SRAM.
//  Revision : 1.0
// ============================================================================
module systolic_drain #(
   parameter int ARRAY_SIZE   = 8,
   parameter int DATA_WIDTH   = 8,
   parameter int CUM_BITS_EXT = 5,
   parameter int ORI_WIDTH    = DATA_WIDTH + DATA_WIDTH + CUM_BITS_EXT,
   parameter int MATRIX_BITS  = 6,
   parameter int ADDR_BITS    = 10,
   parameter int SHIFT_BITS   = 5
) (
   input  logic                             clk,
   input  logic                             srstn,
   input  logic                             drain_start,
   input  logic [ADDR_BITS-1:0]             base_addr,
   input  logic [SHIFT_BITS-1:0]            shift_amt,
   input  logic                             relu_en,
   input  logic [ARRAY_SIZE*ORI_WIDTH-1:0]  mul_outcome,
   output logic [MATRIX_BITS-1:0]           matrix_index,
   output logic                             sram_wen,
   output logic [ADDR_BITS-1:0]             sram_waddr,
   output logic [ARRAY_SIZE*DATA_WIDTH-1:0] sram_wdata,
   input  logic                             sram_wready,
   output logic                             busy,
   output logic                             drain_done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam logic signed [ORI_WIDTH:0] SAT_MAX = (ORI_WIDTH+1)'((1 << (DATA_WIDTH-1)) - 1);
   localparam logic signed [ORI_WIDTH:0] SAT_MIN = ~SAT_MAX;
   localparam logic [MATRIX_BITS-1:0]    LAST_K  = MATRIX_BITS'(ARRAY_SIZE-1);

   state_t                            state_q, state_d;
   logic [MATRIX_BITS-1:0]            k_q, k_d;
   logic [ADDR_BITS-1:0]              base_q;
   logic [SHIFT_BITS-1:0]             shift_q;
   logic                              relu_q;

   logic                              s1_vld_q;
   logic [ARRAY_SIZE*ORI_WIDTH-1:0]   s1_data_q;
   logic [MATRIX_BITS-1:0]            s1_idx_q;
   logic                              s2_vld_q;
   logic [ARRAY_SIZE*DATA_WIDTH-1:0]  s2_data_q;
   logic [ADDR_BITS-1:0]              s2_addr_q;

   logic                              s2_adv;
   logic                              s1_adv;
   logic                              issue;
   logic                              final_accept;
   logic [ARRAY_SIZE*DATA_WIDTH-1:0]  q_word;

   // Rounding right shift (half toward +inf) with one guard bit, then
   // saturate to the output width and optionally clamp negatives.
   function automatic logic [DATA_WIDTH-1:0] requant(
      input logic signed [ORI_WIDTH-1:0] x,
      input logic [SHIFT_BITS-1:0]       sh,
      input logic                        relu
   );
      logic [SHIFT_BITS-1:0]      s;
      logic signed [ORI_WIDTH:0]  ext;
      logic signed [ORI_WIDTH:0]  half;
      logic signed [ORI_WIDTH:0]  y;
      logic [DATA_WIDTH-1:0]      r;
      if (32'(sh) > ORI_WIDTH-1) s = SHIFT_BITS'(ORI_WIDTH-1);
      else                       s = sh;
      ext = {x[ORI_WIDTH-1], x};
      if (s == '0) begin
         y = ext;
      end else begin
         half = {{ORI_WIDTH{1'b0}}, 1'b1} << (s - 1'b1);
         y    = (ext + half) >>> s;
      end
      if (y > SAT_MAX)      r = SAT_MAX[DATA_WIDTH-1:0];
      else if (y < SAT_MIN) r = SAT_MIN[DATA_WIDTH-1:0];
      else                  r = y[DATA_WIDTH-1:0];
      if (relu && r[DATA_WIDTH-1]) r = '0;
      return r;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
         assign q_word[gi*DATA_WIDTH +: DATA_WIDTH] =
            requant(s1_data_q[gi*ORI_WIDTH +: ORI_WIDTH], shift_q, relu_q);
      end
   endgenerate

   // An output stage frees up when empty or when the SRAM takes its word;
   // the capture stage follows whenever the output stage moves.
   assign s2_adv       = !s2_vld_q || sram_wready;
   assign s1_adv       = !s1_vld_q || s2_adv;
   assign issue        = (state_q == ST_DRAIN) && s1_adv;
   assign final_accept = (state_q == ST_FLUSH) && s2_vld_q && sram_wready && !s1_vld_q;

   assign matrix_index = k_q;
   assign sram_wen     = s2_vld_q;
   assign sram_waddr   = s2_addr_q;
   assign sram_wdata   = s2_data_q;
   assign busy         = (state_q != ST_IDLE);

   // Next-state, index counter and completion pulse.
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      drain_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (drain_start) begin
               state_d = ST_DRAIN;
               k_d     = '0;
            end
         end
         ST_DRAIN: begin
            if (issue) begin
               if (k_q == LAST_K) begin
                  state_d = ST_FLUSH;
                  k_d     = '0;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         ST_FLUSH: begin
            if (final_accept) begin
               state_d    = ST_IDLE;
               drain_done = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            k_d     = '0;
         end
      endcase
   end

   // State register and read index.
   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

   // Drain configuration captured once per accepted start.
   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         base_q  <= '0;
         shift_q <= '0;
         relu_q  <= 1'b0;
      end else if (state_q == ST_IDLE && drain_start) begin
         base_q  <= base_addr;
         shift_q <= shift_amt;
         relu_q  <= relu_en;
      end
   end

   // Two-stage pipe: raw vector capture, then requantized word to SRAM.
   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         s1_vld_q  <= 1'b0;
         s1_data_q <= '0;
         s1_idx_q  <= '0;
         s2_vld_q  <= 1'b0;
         s2_data_q <= '0;
         s2_addr_q <= '0;
      end else begin
         if (s1_adv) begin
            s1_vld_q <= issue;
            if (issue) begin
               s1_data_q <= mul_outcome;
               s1_idx_q  <= k_q;
            end
         end
         if (s2_adv) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
               s2_data_q <= q_word;
               s2_addr_q <= base_q + ADDR_BITS'(s1_idx_q);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
Output-side companion to the parameterized systolic array. After a compute pass, it walks the array's diagonal read port by stepping matrix_index 0..ARRAY_SIZE-1 and captures each ARRAY_SIZE-lane accumulator vector. Each lane is requantized to DATA_WIDTH: rounding right shift, saturation, optional ReLU. The lanes are packed into one SRAM word, and one word per index is written to the output SRAM through a valid/ready write handshake.

Parameters:
ARRAY_SIZE, 8, array dimension; lanes per vector and number of drained vectors
DATA_WIDTH, 8, signed width of each requantized output lane
CUM_BITS_EXT, 5, accumulator sign-extension bits
ORI_WIDTH, DATA_WIDTH+DATA_WIDTH+CUM_BITS_EXT, signed accumulator lane width (21)
MATRIX_BITS, 6, width of matrix_index
ADDR_BITS, 10, output SRAM address width
SHIFT_BITS, 5, width of shift_amt

Ports:
clk  in  1  clock, rising edge
srstn  in  1  asynchronous active-low reset
drain_start  in  1  single-cycle request; honoured only in IDLE
base_addr  in  ADDR_BITS  first SRAM address; latched on accepted start
shift_amt  in  SHIFT_BITS  requant right-shift; latched on accepted start
relu_en  in  1  clamp negatives to 0; latched on accepted start
mul_outcome  in  ARRAY_SIZE*ORI_WIDTH  array read data; combinational function of matrix_index
matrix_index  out  MATRIX_BITS  array read index (registered)
sram_wen  out  1  write valid
sram_waddr  out  ADDR_BITS  write address
sram_wdata  out  ARRAY_SIZE*DATA_WIDTH  packed write data; lane i at [i*DATA_WIDTH +: DATA_WIDTH]
sram_wready  in  1  SRAM accepts the write this cycle
busy  out  1  high in any state other than IDLE
drain_done  out  1  one-cycle pulse when the last word is accepted

Behaviour:
- Reset (async, srstn=0): state IDLE, index counter 0, both pipe stages invalid.
- Reset output values: matrix_index=0, sram_wen=0, sram_waddr=0, sram_wdata=0, busy=0, drain_done=0.
- Reset mid-drain aborts immediately. No partial word is written after reset.
- FSM states: IDLE, DRAIN, FLUSH.
- IDLE -> DRAIN on drain_start=1. Latch base_addr, shift_amt, relu_en. Index counter k=0.
- drain_start in DRAIN or FLUSH is ignored.
- Pipe stage S1 holds the raw vector plus its index. Stage S2 holds the quantized word plus address.
- S2 advances when S2 is empty, or when sram_wen & sram_wready.
- S1 advances when S1 is empty, or when S2 advances.
- Issue in DRAIN: when S1 can load, capture mul_outcome (for current matrix_index=k) into S1, then k++.
- DRAIN -> FLUSH after issuing k=ARRAY_SIZE-1. matrix_index returns to 0 in FLUSH and IDLE.
- FLUSH -> IDLE in the cycle the final word is accepted. drain_done=1 in that same cycle.
- Latency: index k presented at cycle t -> sram_wen with that word at t+2 when there is no backpressure.
- Throughput: one word per cycle with sram_wready held high. ARRAY_SIZE=8 drains in 10 cycles from the first DRAIN cycle.
- Backpressure: while sram_wen=1 and sram_wready=0, sram_wen, sram_waddr and sram_wdata hold stable. S1 and matrix_index also hold if S1 is full.
- sram_waddr = base_addr + k, modulo 2^ADDR_BITS (wraps).
- Requant, per lane x (signed ORI_WIDTH), with s = min(shift_amt, ORI_WIDTH-1):
  - s=0: y = x.
  - s>0: y = (x + 2^(s-1)) >>> s. Compute in ORI_WIDTH+1 bits so there is no overflow (round half toward +inf).
  - Saturate y to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - If relu_en, negative results become 0.
- The array contents must remain stable during a drain; upstream holds alu_start=0. This block does not check that.

Test Plan:
- Reset held mid-drain at k=3, then released -> all outputs 0, state IDLE, no further sram_wen until a new drain_start.
- base_addr=100, shift=0, relu=0, lane i of index k = 8k+i, wready=1 -> words at addresses 100..107, one per cycle, first at t+2. Lane i of word k = 8k+i. drain_done pulses with the final write.
- Rounding and saturation with shift=1: lanes {5, -3, -4, 300, -300, 255} -> {3, -1, -2, 127, -128, 127}. Same lanes with relu=1 -> {3, 0, 0, 127, 0, 127}.
- shift_amt=31 with lane = 2^20-1 -> s clamps to 20 -> output 1. Lane -2^20 -> output -1.
- wready low for 3 cycles on word 2 -> word 2 held stable, matrix_index stalls at 4. Words in order with no loss or duplication. Total drain time grows by exactly 3 cycles.
- drain_start pulsed during DRAIN with base_addr=500 -> ignored; addresses continue from the original base. base_addr=1020 -> addresses wrap 1020..1023, then 0..3.
